dadda_mac_pipe: RTL and testbench
=================================

# dadda_mac_pipe

Parametrised, three-stage pipelined unsigned multiply-accumulate unit built on a Dadda reduction tree. It generalises the existing combinational 8x8 multiply-plus-addend datapath to a WIDTH-bit multiplier with a valid/ready handshake and full-throughput pipelining. It adds a mode with a persistent wide accumulator. It sits between an operand source and a result consumer, each of which may stall.

## Interface
- WIDTH, 8: operand width of a and b; m is 2*WIDTH bits.
- GUARD, 8: accumulator guard bits; ACC_W = 2*WIDTH + GUARD. GUARD must be at least 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  unit accepts the transaction this cycle.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- m  input  2*WIDTH  addend in mode 0; accumulator load value in mode 1 when clr=1.
- mode  input  1  0 = res = a*b + m; 1 = accumulate.
- clr  input  1  mode 1 only: the accumulator base is m, zero-extended, instead of the current accumulator.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result this cycle.
- res  output  ACC_W  result, zero-extended in mode 0.

## Operation
- Transfer in: in_valid && in_ready on an edge. Transfer out: out_valid && out_ready on an edge.
- Stage 1 (S1): generate WIDTH*WIDTH partial products and run Dadda reduction down to about 4 rows. Register the rows, m, mode, clr and a valid bit.
- Stage 2 (S2): reduce to two rows with full/half adders. Register the two rows, m, mode, clr and a valid bit.
- Stage 3 (S3, output register): final carry-propagate add.
  - Mode 0: res = a*b + m. This is exact (at most 2*WIDTH+1 bits) and is zero-extended to ACC_W.
  - Mode 1: base = clr ? m : acc. Then res = (base + a*b) mod 2^ACC_W, and acc is set to the same value.
- acc changes only when a mode-1 transaction enters S3. Mode-0 transactions never read or write acc.
- Consecutive mode-1 transactions chain correctly with no gap, because acc is read and written in S3 only.
- Stall control: en = !out_valid || out_ready. All three stages advance together when en=1 and hold completely when en=0.
- in_ready = en, driven combinationally from out_valid and out_ready only (it does not depend on in_valid).
- Bubbles travel as invalid stage entries. A bubble entering S3 does not touch acc and deasserts out_valid.
- res and out_valid stay stable while out_valid && !out_ready.
- Results come out in acceptance order; none are dropped or duplicated.
- rst: clears all stage valid bits, out_valid, res and acc to 0. In-flight transactions are discarded. The rst cycle overrides any concurrent transfer in or out.

## Timing
- Reset values: in_ready=1 (since out_valid=0), out_valid=0, res=0, acc=0.
- Latency: a transaction accepted at edge k appears with out_valid=1 at edge k+3 when unstalled.
- Throughput: one transaction per cycle under continuous in_valid and out_ready.
- Under out_ready=0 the pipeline holds at most 3 transactions. in_ready falls once S3 holds a valid result.
- Simultaneous transfer in and transfer out on the same edge is allowed and sustains full rate.
- Reset mid-operation: out_valid=0 on the edge after rst rises. The first transaction accepted after rst falls uses acc=0.

## Test plan
- Mode 0 maximum (WIDTH=8, GUARD=8): a=255, b=255, m=65535 with out_ready=1 gives res=0x01FE00 (130560) exactly 3 cycles after acceptance.
- Accumulate chain: (mode1, clr=1, m=10, a=3, b=4) then (mode1, clr=0, a=5, b=5), back to back, gives res=22 then res=47 on consecutive cycles.
- Wrap: clr=1, m=0, a=b=255, then 258 more mode-1 transactions with a=b=255 and clr=0. The final res is 0x00FB03 (16841475 mod 2^24).
- Backpressure: out_ready=0 with in_valid held high and mode-0 operands (1,1,0), (2,2,0), (3,3,0), (4,4,0).
  - Exactly 3 are accepted and in_ready goes low.
  - Raising out_ready delivers 1, 4, 9, 16 in order with res held stable while stalled.
- Mode isolation: mode1 clr=1 m=100 a=1 b=1 gives 101. Then mode0 a=2 b=2 m=7 gives 11. Then mode1 clr=0 a=1 b=1 gives 102.
- Reset mid-flight: assert rst for 1 cycle with 2 transactions in flight; out_valid=0 and nothing from them emerges. A following mode1 clr=0 a=2 b=3 gives 6.

Source files
------------

// File: rtl/dadda_mac_pipe.sv
// Three-stage pipelined unsigned multiply-accumulate on a Dadda tree.
// S1: partial products reduced to at most four rows. S2: reduced to two rows.
// S3: carry-propagate add into the output register, plus the persistent
// accumulator for mode 1. All stages share one stall enable.
// GUARD must be at least 1 so the mode-0 sum (2*WIDTH+1 bits) fits in res.
module dadda_mac_pipe #(
  parameter int WIDTH = 8,
  parameter int GUARD = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           a_i,
  input  logic [WIDTH-1:0]           b_i,
  input  logic [2*WIDTH-1:0]         m_i,
  input  logic                       mode_i,
  input  logic                       clr_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [2*WIDTH+GUARD-1:0]   res_o
);

  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = PW + GUARD;
  localparam int CH    = (WIDTH < 2) ? 2 : WIDTH;  // column capacity
  localparam int BUF   = 2 * CH + 2;               // column bits plus incoming carries
  localparam int R1    = (WIDTH < 4) ? WIDTH : 4;  // rows left after S1

  // bit matrix: one entry per column of weight 2^c, bits packed from index 0
  typedef logic [PW-1:0][CH-1:0] mat_t;
  typedef logic [PW-1:0][15:0]   hgt_t;

  // One Dadda pass: bring every column down to height d, LSB column first,
  // so carries produced in column c are counted in the height of column c+1.
  function automatic void dadda_step(input mat_t mi, input hgt_t hi, input int d,
                                     output mat_t mo, output hgt_t ho);
    logic [BUF-1:0] bits;
    logic [CH:0]    cy;
    logic [CH:0]    cy_n;
    int ncy, n, e, nfa, nha, k, o;
    mo  = '0;
    ho  = '0;
    cy  = '0;
    ncy = 0;
    for (int c = 0; c < PW; c++) begin
      bits = '0;
      n    = 0;
      for (int i = 0; i < CH; i++)
        if (i < int'(hi[c])) begin
          bits[n] = mi[c][i];
          n++;
        end
      for (int i = 0; i <= CH; i++)
        if (i < ncy) begin
          bits[n] = cy[i];
          n++;
        end
      e    = (n > d) ? n - d : 0;
      nfa  = e / 2;
      nha  = e % 2;
      cy_n = '0;
      k    = 0;
      o    = 0;
      for (int f = 0; f < CH; f++)
        if (f < nfa) begin
          mo[c][o] = bits[k] ^ bits[k+1] ^ bits[k+2];
          cy_n[f]  = (bits[k] & bits[k+1]) | (bits[k+2] & (bits[k] ^ bits[k+1]));
          k += 3;
          o++;
        end
      if (nha == 1) begin
        mo[c][o]   = bits[k] ^ bits[k+1];
        cy_n[nfa]  = bits[k] & bits[k+1];
        k += 2;
        o++;
      end
      for (int i = 0; i < BUF; i++)
        if (i >= k && i < n) begin
          mo[c][o] = bits[i];
          o++;
        end
      ho[c] = 16'(o);
      cy    = cy_n;
      ncy   = nfa + nha;
    end
  endfunction

  // Partial-product matrix followed by the Dadda passes whose targets are >= 4.
  // Carries out of the top column are always zero since a*b < 2^PW.
  function automatic mat_t s1_reduce(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    mat_t m0, m1;
    hgt_t h0, h1;
    int   dseq [16];
    int   cnt;
    m0 = '0;
    h0 = '0;
    for (int c = 0; c < PW; c++) begin
      cnt = 0;
      for (int i = 0; i < WIDTH; i++)
        if (c - i >= 0 && c - i < WIDTH) begin
          m0[c][cnt] = a[i] & b[c-i];
          cnt++;
        end
      h0[c] = 16'(cnt);
    end
    dseq[0] = 2;
    for (int j = 1; j < 16; j++) dseq[j] = (dseq[j-1] * 3) / 2;
    for (int j = 15; j >= 0; j--)
      if (dseq[j] >= 4 && dseq[j] < WIDTH) begin
        dadda_step(m0, h0, dseq[j], m1, h1);
        m0 = m1;
        h0 = h1;
      end
    return m0;
  endfunction

  // Final two Dadda passes (targets 3 and 2). Every column is treated as full
  // height R1; positions that S1 left empty are constant zero and fold away.
  function automatic mat_t s2_reduce(input logic [R1-1:0][PW-1:0] rows);
    mat_t m0, m1;
    hgt_t h0, h1;
    m0 = '0;
    h0 = '0;
    for (int c = 0; c < PW; c++) begin
      for (int r = 0; r < R1; r++) m0[c][r] = rows[r][c];
      h0[c] = 16'(R1);
    end
    dadda_step(m0, h0, 3, m1, h1);
    dadda_step(m1, h1, 2, m0, h0);
    return m0;
  endfunction

  logic                    en;
  mat_t                    s1_mat_d, s2_mat_d;
  logic [R1-1:0][PW-1:0]   s1_rows_d, s1_rows_q;
  logic [PW-1:0]           s2_r0_d, s2_r1_d, s2_r0_q, s2_r1_q;
  logic [PW-1:0]           s1_m_q, s2_m_q;
  logic                    s1_mode_q, s1_clr_q, s1_valid_q;
  logic                    s2_mode_q, s2_clr_q, s2_valid_q;
  logic [PW-1:0]           prod_d;
  logic [PW:0]             sum0_d;
  logic [ACC_W-1:0]        base_d, acc_d, res_d;
  logic [ACC_W-1:0]        acc_q, res_q;
  logic                    out_valid_q;

  assign en          = !out_valid_q || out_ready_i;
  assign in_ready_o  = en;
  assign out_valid_o = out_valid_q;
  assign res_o       = res_q;

  // S1 combinational: partial products down to R1 rows
  always_comb begin
    s1_rows_d = '0;
    s1_mat_d  = s1_reduce(a_i, b_i);
    for (int r = 0; r < R1; r++)
      for (int c = 0; c < PW; c++)
        s1_rows_d[r][c] = s1_mat_d[c][r];
  end

  // S2 combinational: R1 rows down to a sum row and a carry row
  always_comb begin
    s2_r0_d  = '0;
    s2_r1_d  = '0;
    s2_mat_d = s2_reduce(s1_rows_q);
    for (int c = 0; c < PW; c++) begin
      s2_r0_d[c] = s2_mat_d[c][0];
      s2_r1_d[c] = s2_mat_d[c][1];
    end
  end

  // S3 combinational: carry-propagate add and accumulator update
  always_comb begin
    prod_d = s2_r0_q + s2_r1_q;
    sum0_d = {1'b0, prod_d} + {1'b0, s2_m_q};
    base_d = s2_clr_q ? ACC_W'(s2_m_q) : acc_q;
    acc_d  = base_d + ACC_W'(prod_d);
    res_d  = s2_mode_q ? acc_d : ACC_W'(sum0_d);
  end

  // S1 register: reduced rows and sideband, advancing only when enabled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_rows_q  <= '0;
      s1_m_q     <= '0;
      s1_mode_q  <= 1'b0;
      s1_clr_q   <= 1'b0;
    end else if (en) begin
      s1_valid_q <= in_valid_i;
      s1_rows_q  <= s1_rows_d;
      s1_m_q     <= m_i;
      s1_mode_q  <= mode_i;
      s1_clr_q   <= clr_i;
    end
  end

  // S2 register: two rows and sideband
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      s2_r0_q    <= '0;
      s2_r1_q    <= '0;
      s2_m_q     <= '0;
      s2_mode_q  <= 1'b0;
      s2_clr_q   <= 1'b0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      s2_r0_q    <= s2_r0_d;
      s2_r1_q    <= s2_r1_d;
      s2_m_q     <= s1_m_q;
      s2_mode_q  <= s1_mode_q;
      s2_clr_q   <= s1_clr_q;
    end
  end

  // S3 register: result, out_valid and accumulator; bubbles leave acc alone
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      acc_q       <= '0;
    end else if (en) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        res_q <= res_d;
        if (s2_mode_q) acc_q <= acc_d;
      end
    end
  end

endmodule

// File: tb/tb_dadda_mac_pipe.sv
// Bench for dadda_mac_pipe (WIDTH=8, GUARD=8): table vectors, hand sequences
// for latency, wrap, backpressure and reset, and a queue-based scoreboard.
module tb_dadda_mac_pipe;

  localparam int WIDTH = 8;
  localparam int GUARD = 8;
  localparam int ACC_W = 2 * WIDTH + GUARD;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0]  a_in, b_in;
  logic [2*WIDTH-1:0] m_in;
  logic              mode_in, clr_in;
  logic [ACC_W-1:0]  res;

  initial forever #5 clk = ~clk;

  dadda_mac_pipe #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a_in), .b_i(b_in), .m_i(m_in), .mode_i(mode_in), .clr_i(clr_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .res_o(res)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] m;
    logic        md;
    logic        cl;
    logic [23:0] ev;
  } vec_t;

  int               n_pass = 0;
  int               n_total = 0;
  int               out_cnt = 0;
  int               cyc = 0;
  logic [ACC_W-1:0] exp_q [$];
  logic [ACC_W-1:0] acc_m = '0;
  logic [ACC_W-1:0] last_res = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // scoreboard: every result transfer is compared with the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got res %0d, expected no output", res);
      end else begin
        check("res", 32'(res), 32'(exp_q.pop_front()));
      end
      last_res = res;
      out_cnt++;
    end
  end

  function automatic void push_model(input logic [7:0] a, input logic [7:0] b,
                                     input logic [15:0] m, input logic md, input logic cl);
    logic [ACC_W-1:0] p;
    logic [ACC_W-1:0] base;
    p = ACC_W'(a) * ACC_W'(b);
    if (!md) exp_q.push_back(p + ACC_W'(m));
    else begin
      base  = cl ? ACC_W'(m) : acc_m;
      acc_m = base + p;
      exp_q.push_back(acc_m);
    end
  endfunction

  // present one transaction (called at posedge+1) and wait until it is taken
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] m,
                      input logic md, input logic cl, input bit use_ev, input logic [23:0] ev);
    int   w;
    logic took;
    w = 0;
    took = 1'b0;
    in_valid = 1'b1; a_in = a; b_in = b; m_in = m; mode_in = md; clr_in = cl;
    do begin
      @(negedge clk);
      took = in_ready;
      if (took) begin
        if (use_ev) begin
          exp_q.push_back(ev);
          if (md) acc_m = ev;
        end else push_model(a, b, m, md, cl);
      end
      @(posedge clk); #1;
      w++;
    end while (!took && w < 100);
    if (!took) begin
      n_total++;
      $display("FAIL send_timeout: got no acceptance in %0d cycles, expected acceptance", w);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t tbl [12];
  int   t0, nacc, cnt0;
  logic [ACC_W-1:0] hold;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{8'd0,   8'd0,   16'd0,     1'b0, 1'b0, 24'd0};
    tbl[1]  = '{8'd255, 8'd255, 16'd65535, 1'b0, 1'b0, 24'd130560};
    tbl[2]  = '{8'd1,   8'd255, 16'd0,     1'b0, 1'b0, 24'd255};
    tbl[3]  = '{8'd16,  8'd16,  16'd5,     1'b0, 1'b0, 24'd261};
    tbl[4]  = '{8'd170, 8'd85,  16'd1234,  1'b0, 1'b0, 24'd15684};
    tbl[5]  = '{8'd3,   8'd4,   16'd10,    1'b1, 1'b1, 24'd22};
    tbl[6]  = '{8'd5,   8'd5,   16'd0,     1'b1, 1'b0, 24'd47};
    tbl[7]  = '{8'd1,   8'd1,   16'd100,   1'b1, 1'b1, 24'd101};
    tbl[8]  = '{8'd2,   8'd2,   16'd7,     1'b0, 1'b0, 24'd11};
    tbl[9]  = '{8'd1,   8'd1,   16'd0,     1'b1, 1'b0, 24'd102};
    tbl[10] = '{8'd255, 8'd255, 16'd65535, 1'b1, 1'b1, 24'd130560};
    tbl[11] = '{8'd128, 8'd2,   16'd0,     1'b0, 1'b0, 24'd256};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; m_in = '0; mode_in = 1'b0; clr_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_res", 32'(res), 32'd0);

    // latency: operands presented now appear after the third rising edge
    out_ready = 1'b1;
    in_valid = 1'b1; a_in = 8'd255; b_in = 8'd255; m_in = 16'hFFFF; mode_in = 1'b0; clr_in = 1'b0;
    @(negedge clk);
    check("lat_in_ready", 32'(in_ready), 32'd1);
    push_model(8'd255, 8'd255, 16'hFFFF, 1'b0, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge2_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge3_valid", 32'(out_valid), 32'd1);
    check("lat_res", 32'(res), 32'h01FE00);
    drain();

    // table vectors back to back at full rate
    t0 = cyc;
    for (int i = 0; i < 12; i++)
      send(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].md, tbl[i].cl, 1'b1, tbl[i].ev);
    check("throughput_cycles", 32'(cyc - t0), 32'd12);
    drain();

    // accumulator wrap
    send(8'd255, 8'd255, 16'd0, 1'b1, 1'b1, 1'b0, 24'd0);
    for (int i = 0; i < 258; i++) send(8'd255, 8'd255, 16'd0, 1'b1, 1'b0, 1'b0, 24'd0);
    drain();
    check("wrap_final", 32'(last_res), 32'h00FB03);

    // backpressure: three accepted, then ordered delivery
    out_ready = 1'b0;
    nacc = 0;
    cnt0 = out_cnt;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; a_in = 8'(nacc + 1); b_in = 8'(nacc + 1); m_in = '0; mode_in = 1'b0; clr_in = 1'b0;
      @(negedge clk);
      if (in_ready) begin
        push_model(8'(nacc + 1), 8'(nacc + 1), 16'd0, 1'b0, 1'b0);
        nacc++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepted", 32'(nacc), 32'd3);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    hold = res;
    repeat (3) @(posedge clk);
    #1;
    check("bp_res_stable", 32'(res), 32'(hold));
    check("bp_res_first", 32'(res), 32'd1);
    out_ready = 1'b1;
    send(8'd4, 8'd4, 16'd0, 1'b0, 1'b0, 1'b0, 24'd0);
    drain();
    check("bp_delivered", 32'(out_cnt - cnt0), 32'd4);

    // reset with two transactions in flight
    send(8'd9, 8'd9, 16'd500, 1'b1, 1'b1, 1'b0, 24'd0);
    send(8'd7, 8'd7, 16'd0, 1'b1, 1'b0, 1'b0, 24'd0);
    rst = 1'b1;
    exp_q.delete();
    acc_m = '0;
    cnt0 = out_cnt;
    @(posedge clk); #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_no_output", 32'(out_cnt - cnt0), 32'd0);
    send(8'd2, 8'd3, 16'd0, 1'b1, 1'b0, 1'b0, 24'd0);
    drain();
    check("rst_acc_zero", 32'(last_res), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
